// File: rtl/gate_truth_table_tester.sv
//------------------------------------------------------------------------------
// Module   : gate_truth_table_tester
// Purpose  : Walks a two-input gate block through all four input vectors and
//            checks its eight results against the truth table.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_truth_table_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic [7:0] gate_bus_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       pass_out,
    output logic [7:0] fail_mask_out,
    output logic [3:0] fail_vec_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       w_expected;
    logic [7:0]       w_mism;
    logic [7:0]       w_mask_next;

    // Bit order: [0] and, [1] or, [2] xor, [3] a-not, [4] b-not, [5] nand, [6] nor, [7] xnor
    always_comb begin
        w_expected = 8'hF8;
        case (r_vec)
            2'd0: w_expected = 8'hF8;
            2'd1: w_expected = 8'h2E;
            2'd2: w_expected = 8'h36;
            2'd3: w_expected = 8'h83;
            default: w_expected = 8'hF8;
        endcase
    end

    assign w_mism      = gate_bus_in ^ w_expected;
    assign w_mask_next = fail_mask_out | w_mism;

    // The vector index is itself the registered a/b drive.
    assign a_out = r_vec[1];
    assign b_out = r_vec[0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_vec         <= 2'd0;
            r_cnt         <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            pass_out      <= 1'b0;
            fail_mask_out <= 8'h00;
            fail_vec_out  <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_vec         <= 2'd0;
                        r_cnt         <= '0;
                        busy_out      <= 1'b1;
                        pass_out      <= 1'b0;
                        fail_mask_out <= 8'h00;
                        fail_vec_out  <= 4'h0;
                        r_state       <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_settle_last) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    fail_mask_out <= w_mask_next;
                    if (w_mism != 8'h00) begin
                        fail_vec_out[r_vec] <= 1'b1;
                    end
                    if (r_vec == 2'd3) begin
                        // Summary is published on entry so it is valid alongside done_out.
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                        pass_out <= (w_mask_next == 8'h00);
                        r_state  <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + 2'd1;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    done_out <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_table_tester.sv
//------------------------------------------------------------------------------
// Module   : tb_gate_truth_table_tester
// Purpose  : Scoreboard bench for gate_truth_table_tester with a fault-injectable
//            gate model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gate_truth_table_tester;

    typedef struct {
        int         t0;
        int         t_done;
        logic       pass;
        logic [7:0] mask;
        logic [3:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] bus0, bus1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [7:0] mask0, mask1;
    logic [3:0] vec0, vec1;
    int         fault = 0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gates(input logic a, input logic b);
        return {~(a ^ b), ~(a | b), ~(a & b), ~b, ~a, a ^ b, a | b, a & b};
    endfunction

    always_comb begin
        bus0 = gates(a0, b0);
        if (fault == 1) bus0[2] = 1'b0;
        if (fault == 2) begin
            bus0[0] = ~bus0[0];
            bus0[5] = ~bus0[5];
        end
    end
    assign bus1 = gates(a1, b1);

    gate_truth_table_tester #(.SETTLE_CYCLES(2), .CNT_W(4)) dut0 (
        .clk_in(clk), .rst_in(rst), .start_in(start0), .gate_bus_in(bus0),
        .a_out(a0), .b_out(b0), .busy_out(busy0), .done_out(done0),
        .pass_out(pass0), .fail_mask_out(mask0), .fail_vec_out(vec0)
    );

    gate_truth_table_tester #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start1), .gate_bus_in(bus1),
        .a_out(a1), .b_out(b1), .busy_out(busy1), .done_out(done1),
        .pass_out(pass1), .fail_mask_out(mask1), .fail_vec_out(vec1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor for the SETTLE_CYCLES=2 instance (3 cycles per vector).
    always @(negedge clk) begin
        if (!rst) begin
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("dut0_unexpected_done", 1, 0);
                end else begin
                    chk("dut0_done_cycle", cyc, q0[0].t_done);
                    chk("dut0_pass", int'(pass0), int'(q0[0].pass));
                    chk("dut0_fail_mask", int'(mask0), int'(q0[0].mask));
                    chk("dut0_fail_vec", int'(vec0), int'(q0[0].vec));
                    chk("dut0_busy_at_done", int'(busy0), 0);
                    void'(q0.pop_front());
                end
            end else if (q0.size() > 0 && cyc > q0[0].t0 && cyc <= q0[0].t0 + 12) begin
                chk("dut0_ab", int'({a0, b0}), (cyc - q0[0].t0 - 1) / 3);
                chk("dut0_busy", int'(busy0), 1);
            end
        end
    end

    // Monitor for the SETTLE_CYCLES=1 instance (2 cycles per vector).
    always @(negedge clk) begin
        if (!rst) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_done", 1, 0);
                end else begin
                    chk("dut1_done_cycle", cyc, q1[0].t_done);
                    chk("dut1_pass", int'(pass1), int'(q1[0].pass));
                    chk("dut1_fail_mask", int'(mask1), int'(q1[0].mask));
                    chk("dut1_fail_vec", int'(vec1), int'(q1[0].vec));
                    void'(q1.pop_front());
                end
            end else if (q1.size() > 0 && cyc > q1[0].t0 && cyc <= q1[0].t0 + 8) begin
                chk("dut1_ab", int'({a1, b1}), (cyc - q1[0].t0 - 1) / 2);
            end
        end
    end

    task automatic push0(input int t0, input logic p, input logic [7:0] m, input logic [3:0] v);
        exp_t e;
        e.t0 = t0; e.t_done = t0 + 13; e.pass = p; e.mask = m; e.vec = v;
        q0.push_back(e);
    endtask

    task automatic run0(input logic p, input logic [7:0] m, input logic [3:0] v);
        @(negedge clk);
        start0 = 1'b1;
        push0(cyc, p, m, v);
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_q0(input int budget);
        int n = 0;
        while (q0.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0) begin
            chk("dut0_timeout", q0.size(), 0);
            q0.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_held0(input string nm, input logic p, input logic [7:0] m, input logic [3:0] v);
        repeat (3) @(negedge clk);
        chk({nm, "_held_pass"}, int'(pass0), int'(p));
        chk({nm, "_held_mask"}, int'(mask0), int'(m));
        chk({nm, "_held_vec"}, int'(vec0), int'(v));
    endtask

    task automatic check_zero0(input string nm);
        chk({nm, "_a"}, int'(a0), 0);
        chk({nm, "_b"}, int'(b0), 0);
        chk({nm, "_busy"}, int'(busy0), 0);
        chk({nm, "_done"}, int'(done0), 0);
        chk({nm, "_pass"}, int'(pass0), 0);
        chk({nm, "_mask"}, int'(mask0), 0);
        chk({nm, "_vec"}, int'(vec0), 0);
    endtask

    initial begin
        int t0;
        exp_t e;
        repeat (3) @(negedge clk);
        check_zero0("reset");
        rst = 1'b0;

        // Correct gate block
        fault = 0;
        run0(1'b1, 8'h00, 4'h0);
        wait_q0(40);
        check_held0("good", 1'b1, 8'h00, 4'h0);

        // xor stuck at 0
        fault = 1;
        run0(1'b0, 8'h04, 4'b0110);
        wait_q0(40);
        check_held0("xor_stuck", 1'b0, 8'h04, 4'b0110);

        // and/nand swapped
        fault = 2;
        run0(1'b0, 8'h21, 4'b1111);
        wait_q0(40);
        check_held0("swap", 1'b0, 8'h21, 4'b1111);

        // Starts while busy are ignored
        fault = 0;
        run0(1'b1, 8'h00, 4'h0);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_q0(40);

        // start held high: back-to-back runs separated by one IDLE cycle
        @(negedge clk);
        start0 = 1'b1;
        t0 = cyc;
        push0(t0, 1'b1, 8'h00, 4'h0);
        push0(t0 + 14, 1'b1, 8'h00, 4'h0);
        repeat (16) @(negedge clk);
        start0 = 1'b0;
        wait_q0(60);

        // Reset mid-run aborts without a done pulse
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero0("abort");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run0(1'b1, 8'h00, 4'h0);
        wait_q0(40);

        // SETTLE_CYCLES=1 instance
        @(negedge clk);
        start1 = 1'b1;
        e.t0 = cyc; e.t_done = cyc + 9; e.pass = 1'b1; e.mask = 8'h00; e.vec = 4'h0;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 30 && q1.size() != 0; n++) @(negedge clk);
        if (q1.size() != 0) begin
            chk("dut1_timeout", q1.size(), 0);
            q1.delete();
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/gate_truth_table_tester.md
Name: gate_truth_table_tester

Overview:
- Self-checking stimulus/capture stage wrapped around the two-input basic-gate block.
- Drives the block's a/b inputs through all four input combinations and waits a programmable settle time after each.
- Samples the eight gate results and compares them against the expected truth table.
- Reports a registered pass/fail summary with per-gate and per-vector failure masks. Used for on-board self-test of the gate block.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before its results are sampled. Legal range 1..15.
- CNT_W, 4, width of the settle counter. Must hold SETTLE_CYCLES-1.

Ports:
- clk_in  input  1  single system clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  begin a test run. Sampled only in IDLE.
- gate_bus_in  input  8  results from the gate block. Bit order: [0] and, [1] or, [2] xor, [3] a-not, [4] b-not, [5] nand, [6] nor, [7] xnor.
- a_out  output  1  drives the gate block's a input.
- b_out  output  1  drives the gate block's b input.
- busy_out  output  1  high from start acceptance until the DONE state is reached.
- done_out  output  1  one-cycle pulse marking the end of a run.
- pass_out  output  1  high when the last run had no mismatches. Held until the next start.
- fail_mask_out  output  8  OR of per-gate mismatches over all vectors. Held.
- fail_vec_out  output  4  bit v set if vector v had any mismatch. Held.

Behaviour:
- Reset (rst_in=1 at an edge):
  - state <= IDLE.
  - a_out, b_out, busy_out, done_out, pass_out all 0.
  - fail_mask_out, fail_vec_out, vector index and settle counter all 0.
  - Reset during a run aborts it: no done_out pulse, results cleared.
- Vector index v (2 bits): a_out = v[1], b_out = v[0]. Sequence is (a,b) = 00, 01, 10, 11.
- Expected gate_bus_in per vector: v0 = 0xF8, v1 = 0x2E, v2 = 0x36, v3 = 0x83.
- All outputs are registered. No combinational path from gate_bus_in to any output.
- FSM states:
  - IDLE
    - If start_in=1: v<=0, a_out/b_out<=0, cnt<=0, busy_out<=1, pass_out<=0, fail_mask_out<=0, fail_vec_out<=0; go to SETTLE.
    - Otherwise stay in IDLE. Previous results are held.
  - SETTLE
    - cnt increments each cycle.
    - When cnt == SETTLE_CYCLES-1, go to SAMPLE.
    - a_out/b_out are stable throughout.
  - SAMPLE (one cycle)
    - mism = gate_bus_in XOR expected(v).
    - fail_mask_out <= fail_mask_out | mism.
    - If mism != 0, set fail_vec_out[v].
    - If v == 3: go to DONE.
    - Else: v <= v+1, update a_out/b_out, cnt <= 0, go to SETTLE.
  - DONE (one cycle)
    - done_out = 1, busy_out <= 0.
    - pass_out <= (final fail_mask_out == 0). Must include the v3 sample result.
    - Go to IDLE.
- Latency:
  - Start accepted at edge E.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - DONE is entered at edge E + 4*(SETTLE_CYCLES+1); done_out is high for the cycle after that edge.
  - Default parameters: done_out is high 12 cycles after start is accepted.
- start_in is ignored in SETTLE, SAMPLE and DONE; it is not queued. A start held high through DONE is accepted in the following IDLE cycle.
- pass_out, fail_mask_out and fail_vec_out are stable from the DONE cycle until the next accepted start.
- Simultaneous rst_in and start_in: reset wins.

Test Plan:
1. Correct gate block connected, default parameters, start pulse at cycle 0 -> a/b step 00, 01, 10, 11, each held 3 cycles; done_out pulses in cycle 12; pass_out=1, fail_mask_out=0x00, fail_vec_out=0x0.
2. Bench model with xor output stuck at 0 -> fail_mask_out=0x04, fail_vec_out=0b0110, pass_out=0.
3. Bench model with the nand and and outputs swapped -> fail_mask_out=0x21, fail_vec_out=0b1111, pass_out=0.
4. start_in pulsed again at cycles 4 and 11 while busy -> ignored; exactly one done_out pulse at cycle 12. start_in held high continuously -> runs restart back-to-back with one IDLE cycle between them.
5. rst_in asserted at cycle 6 of a run -> next cycle all outputs 0 and state IDLE; no done_out pulse; a fresh start completes normally.
6. SETTLE_CYCLES=1 -> each vector held 2 cycles; done_out pulses in cycle 8; results identical to scenario 1.
